// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_ctrl
// Brief    : Run/stop and ratio-switch controller for a power-of-two clock
//            divider. Ratio changes and stops only land on period boundaries,
//            so div_out never produces runt pulses.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_ctrl #(
    parameter int CNT_W     = 4,
    parameter int SEL_W     = 2,
    parameter int RESET_SEL = 0
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active low
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [SEL_W-1:0] cfg_sel,
    output logic             cfg_ready,
    output logic             div_out,
    output logic             tick,
    output logic [SEL_W-1:0] cur_sel,
    output logic             busy
);

    localparam logic [SEL_W-1:0] c_max_sel   = SEL_W'(CNT_W - 1);
    localparam logic [SEL_W-1:0] c_reset_sel = SEL_W'(RESET_SEL);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_pend;
    logic [SEL_W-1:0] r_psel;
    logic [SEL_W-1:0] r_cur_sel;
    logic             r_div;
    logic             r_tick;

    logic [SEL_W-1:0] w_eff;       // select clamped to the counter width
    logic [CNT_W-1:0] w_mask;      // counter bits [eff:0]
    logic [CNT_W-1:0] w_top;       // one-hot on counter bit eff
    logic             w_boundary;  // last cycle of the current period
    logic             w_xfer;      // config handshake completes this cycle

    // Out-of-range selects are clamped rather than rejected.
    assign w_eff = (r_cur_sel > c_max_sel) ? c_max_sel : r_cur_sel;

    generate
        for (genvar i = 0; i < CNT_W; i++) begin : g_mask
            assign w_mask[i] = (SEL_W'(i) <= w_eff);
            assign w_top[i]  = (SEL_W'(i) == w_eff);
        end
    endgenerate

    assign w_boundary = (r_state != ST_IDLE) && (&(r_count | ~w_mask));

    // Ready depends only on flops so the host can never form a comb loop.
    assign cfg_ready = !r_pend;
    assign w_xfer    = cfg_valid && !r_pend;

    assign div_out = r_div;
    assign tick    = r_tick;
    assign cur_sel = r_cur_sel;
    assign busy    = (r_state != ST_IDLE);

    // Controller state, divider counter, pending config and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_pend    <= 1'b0;
            r_psel    <= '0;
            r_cur_sel <= c_reset_sel;
            r_div     <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_count <= '0;
                    r_div   <= 1'b0;
                    r_tick  <= 1'b0;
                    // No period in flight, so a new select can land at once.
                    if (w_xfer) begin
                        r_cur_sel <= cfg_sel;
                    end
                    if (en) begin
                        r_state <= ST_RUN;
                    end
                end

                ST_RUN, ST_DRAIN: begin
                    r_count <= w_boundary ? '0 : (r_count + c_one);
                    r_div   <= |(r_count & w_top);
                    r_tick  <= w_boundary;

                    // A pending select is swapped in only between periods.
                    if (w_boundary && r_pend) begin
                        r_cur_sel <= r_psel;
                        r_pend    <= 1'b0;
                    end
                    // Accepted even on a boundary; it then waits a full period.
                    if (w_xfer) begin
                        r_pend <= 1'b1;
                        r_psel <= cfg_sel;
                    end

                    // Stop is deferred to the end of the running period.
                    if (en) begin
                        r_state <= ST_RUN;
                    end else if (r_state == ST_RUN) begin
                        r_state <= ST_DRAIN;
                    end else if (w_boundary) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_count <= '0;
                    r_div   <= 1'b0;
                    r_tick  <= 1'b0;
                    r_pend  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_ctrl
// Brief    : Scoreboard bench for clk_div_ctrl. Two instances (CNT_W=4 and a
//            CNT_W=3 clamping instance) share the stimulus; a period-level
//            reference model predicts every cycle's outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [1:0] cfg_sel = 2'd0;

    logic       rdy4, div4, tick4, busy4;
    logic [1:0] sel4;
    logic       rdy3, div3, tick3, busy3;
    logic [1:0] sel3;

    clk_div_ctrl #(.CNT_W(4), .SEL_W(2), .RESET_SEL(0)) dut4 (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_sel(cfg_sel),
        .cfg_ready(rdy4), .div_out(div4), .tick(tick4), .cur_sel(sel4), .busy(busy4)
    );

    clk_div_ctrl #(.CNT_W(3), .SEL_W(2), .RESET_SEL(2)) dut3 (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_sel(cfg_sel),
        .cfg_ready(rdy3), .div_out(div3), .tick(tick3), .cur_sel(sel3), .busy(busy3)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int         cyc;
        logic [1:0] div;
        logic [1:0] tick;
        logic [1:0] busy;
        logic [1:0] rdy;
        logic [3:0] sel;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---------------- reference model (period arithmetic) ----------------
    bit m_act[2];
    bit m_drn[2];
    int m_pos[2];
    int m_sel[2];
    bit m_pend[2];
    int m_psel[2];
    bit m_div[2];
    bit m_tick[2];

    function automatic int cnt_of(int k);
        return (k == 0) ? 4 : 3;
    endfunction

    function automatic int period_of(int k);
        int e;
        e = (m_sel[k] < cnt_of(k) - 1) ? m_sel[k] : cnt_of(k) - 1;
        return 1 << (e + 1);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 0; m_drn[k] = 0; m_pos[k] = 0;
            m_sel[k] = (k == 0) ? 0 : 2;
            m_pend[k] = 0; m_psel[k] = 0; m_div[k] = 0; m_tick[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input bit e, input bit v, input int s);
        int p;
        bit xfer, bnd;
        xfer = v && !m_pend[k];
        if (!m_act[k]) begin
            m_div[k] = 0;
            m_tick[k] = 0;
            if (xfer) m_sel[k] = s;
            if (e) begin
                m_act[k] = 1; m_drn[k] = 0; m_pos[k] = 0;
            end
        end else begin
            p = period_of(k);
            bnd = (m_pos[k] == p - 1);
            m_div[k] = (m_pos[k] >= p / 2);   // second half of the period is high
            m_tick[k] = bnd;
            m_pos[k] = bnd ? 0 : m_pos[k] + 1;
            if (bnd && m_pend[k]) begin
                m_sel[k] = m_psel[k]; m_pend[k] = 0;
            end
            if (xfer) begin
                m_pend[k] = 1; m_psel[k] = s;
            end
            if (e) m_drn[k] = 0;
            else if (!m_drn[k]) m_drn[k] = 1;
            else if (bnd) m_act[k] = 0;
        end
    endtask

    // One clock: drive inputs for the coming edge and queue the prediction.
    task automatic cycle(input bit r, input bit e, input bit v, input int s);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r; en = e; cfg_valid = v; cfg_sel = 2'(s);
        if (!r) model_reset();
        else for (int k = 0; k < 2; k++) model_step(k, e, v, s);
        x.cyc  = cyc + 1;
        x.div  = {m_div[1], m_div[0]};
        x.tick = {m_tick[1], m_tick[0]};
        x.busy = {m_act[1], m_act[0]};
        x.rdy  = {!m_pend[1], !m_pend[0]};
        x.sel  = {2'(m_sel[1]), 2'(m_sel[0])};
        q.push_back(x);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t x;
        logic [1:0] a_div, a_tick, a_busy, a_rdy;
        logic [3:0] a_sel;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                x = q.pop_front();
                a_div = {div3, div4}; a_tick = {tick3, tick4};
                a_busy = {busy3, busy4}; a_rdy = {rdy3, rdy4}; a_sel = {sel3, sel4};
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("div_out[%0d]@%0d", k, x.cyc), a_div[k], x.div[k]);
                    chk($sformatf("tick[%0d]@%0d", k, x.cyc), a_tick[k], x.tick[k]);
                    chk($sformatf("busy[%0d]@%0d", k, x.cyc), a_busy[k], x.busy[k]);
                    chk($sformatf("cfg_ready[%0d]@%0d", k, x.cyc), a_rdy[k], x.rdy[k]);
                    chk($sformatf("cur_sel[%0d]@%0d", k, x.cyc), a_sel[2*k +: 2], x.sel[2*k +: 2]);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int seq[9] = '{0, 0, 0, 1, 1, 0, 0, 1, 1};
        int t4[$];
        int t3[$];
        int n, pct;
        bit hit;

        model_reset();
        #2;
        rst = 1'b0; en = 1'b1; cfg_valid = 1'b1; cfg_sel = 2'd1;
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 1);
        chk("reset_div", div4, 0);
        chk("reset_tick", tick4, 0);
        chk("reset_busy", busy4, 0);
        chk("reset_ready", rdy4, 1);
        chk("reset_sel4", sel4, 0);
        chk("reset_sel3", sel3, 2);

        // Release with en=1 and sel=1 offered in IDLE.
        cycle(1, 1, 1, 1);
        for (int i = 0; i < 9; i++) begin
            cycle(1, 1, 0, 0);
            chk($sformatf("start_div[%0d]", i), div4, seq[i]);
            chk($sformatf("start_tick[%0d]", i), tick4, (i == 4 || i == 8) ? 1 : 0);
        end
        chk("start_sel", sel4, 1);

        // Switch to sel=0, then sel=0 -> sel=3 while running.
        cycle(1, 1, 1, 0);
        for (int i = 0; i < 12; i++) cycle(1, 1, 0, 0);
        cycle(1, 1, 1, 3);
        cycle(1, 1, 0, 0);
        chk("switch_ready_low", rdy4, 0);
        for (int i = 0; i < 80; i++) begin
            cycle(1, 1, 0, 0);
            if (tick4) t4.push_back(i);
            if (tick3) t3.push_back(i);
        end
        chk("div16_period", (t4.size() >= 2) ? t4[t4.size()-1] - t4[t4.size()-2] : -1, 16);
        chk("clamp_div8_period", (t3.size() >= 2) ? t3[t3.size()-1] - t3[t3.size()-2] : -1, 8);
        chk("switch_sel", sel4, 3);
        chk("switch_ready_high", rdy4, 1);

        // Stop fully, then run sel=2 and drop en mid-period.
        n = 0;
        while (n < 40 && (busy4 || busy3)) begin cycle(1, 0, 0, 0); n++; end
        chk("stop_to_idle", busy4, 0);
        cycle(1, 0, 1, 2);
        cycle(1, 1, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0);
        for (int i = 0; i < 14; i++) cycle(1, 0, 0, 0);
        chk("drain_busy", busy4, 0);
        chk("drain_div", div4, 0);
        chk("drain_sel", sel4, 2);

        // Transfer on a boundary cycle at sel=1, new sel=2.
        cycle(1, 0, 1, 1);
        cycle(1, 1, 0, 0);
        n = 0; hit = 0;
        while (n < 20 && !hit) begin cycle(1, 1, 0, 0); hit = tick4; n++; end
        chk("bnd_tick_seen", hit, 1);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 1, 2);
        t4.delete();
        for (int i = 0; i < 30; i++) begin
            cycle(1, 1, 0, 0);
            if (tick4) t4.push_back(i);
        end
        chk("bnd_first_tick", (t4.size() >= 1) ? t4[0] : -1, 0);
        chk("bnd_old_period", (t4.size() >= 2) ? t4[1] - t4[0] : -1, 4);
        chk("bnd_new_period", (t4.size() >= 3) ? t4[2] - t4[1] : -1, 8);

        // Randomized traffic against the model.
        pct = 95;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) begin
                case ($urandom_range(0, 2))
                    0: pct = 95;
                    1: pct = 30;
                    default: pct = 100;
                endcase
            end
            cycle(1, $urandom_range(0, 99) < pct, $urandom_range(0, 9) == 0,
                  int'($urandom_range(0, 3)));
        end

        // Asynchronous reset mid-period with a config pending.
        n = 0; hit = 0;
        while (n < 100 && !hit) begin
            cycle(1, 1, 1, 3);
            hit = (rdy4 == 0) && (div4 == 1);
            n++;
        end
        chk("arst_setup", hit, 1);
        #3;
        rst = 1'b0;
        q.delete();
        model_reset();
        #1;
        chk("arst_div", div4, 0);
        chk("arst_tick", tick4, 0);
        chk("arst_busy", busy4, 0);
        chk("arst_ready", rdy4, 1);
        chk("arst_sel4", sel4, 0);
        chk("arst_sel3", sel3, 2);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("arst_release_ready", rdy4, 1);
        for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0);
        @(negedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
